cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning instruction/data bus width; DATA_W >= REG_W+5.
REQ-002 SHALL have parameter REG_W, default 3, meaning register-field width; opcode = inst[REG_W+4:REG_W].
REQ-003 SHALL have parameter NREGS, default 8, meaning register count; NREGS <= 2**REG_W.
REQ-004 Port: clk  in  1  single clock; sequencer flops on falling edge, datapath samples on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: data_bus_in  in  DATA_W  shared data bus.
REQ-007 Port: mem_ready  in  1  memory read complete.
REQ-008 Port: regs_rsel  out  NREGS  one-hot; selected register drives bus.
REQ-009 Port: regs_wsel  out  NREGS  one-hot; selected register loads from bus.
REQ-010 Port: mem_ce, mem_oe, mem_r, mem_w, mem_rst  out  1 each  memory controls.
REQ-011 Port: pc_r, pc_w, pc_inc, pc_rst  out  1 each  PC controls (pc_w = PC loads from bus).
REQ-012 Port: inst_q  out  DATA_W  instruction register.
REQ-013 Port: state_o  out  3  current state; halted  out  1; illegal  out  1  sticky.

Function
REQ-014 States SHALL be RST=0, FETCH=1, DECODE=2, EXEC0=3, EXEC1=4, HALT=5; all other encodings go to HALT.
REQ-015 RST: pc_rst=1, mem_rst=1 for one cycle, then FETCH.
REQ-016 FETCH: mem_ce, mem_oe, mem_r, pc_r, pc_inc, inst_w active; inst_q <= data_bus_in on rising edge; then DECODE.
REQ-017 Memory wait: in any step with mem_r=1, state and controls SHALL hold while mem_ready=0 at the falling edge.
REQ-018 While mem_ready=0 during a mem_r step, write/advance strobes (inst_w, regs_wsel, pc_inc, pc_w) SHALL be gated to 0, so each fires exactly once per completed access.
REQ-019 DECODE: no strobes; opcode 0-4 -> EXEC0 (HLT -> HALT); other opcodes -> illegal=1, HALT.
REQ-020 LDI (op 0): EXEC0 mem read at PC, pc_inc, regs_wsel[rd]=1; then FETCH.
REQ-021 MOV (op 1): EXEC0 mem read at PC, pc_inc, operand latched; EXEC1 regs_rsel[operand[REG_W-1:0]]=1, regs_wsel[rd]=1, one cycle; then FETCH.
REQ-022 JMP (op 2): EXEC0 mem read with pc_r, pc_w, no pc_inc; then FETCH.
REQ-023 HLT (op 3): DECODE -> HALT. NOP (op 4): EXEC0 no strobes, then FETCH.
REQ-024 Register index >= NREGS (rd or MOV source) SHALL set illegal=1 and go to HALT with no write.
REQ-025 HALT: all controls 0, halted=1; left only by reset.
REQ-026 Zero-wait latency: LDI 3, MOV 4, JMP 3, NOP 3 cycles; each wait cycle adds one.
REQ-027 regs_rsel/regs_wsel SHALL be all-zero or one-hot; rd=inst[REG_W-1:0].
REQ-028 mem_w SHALL stay 0 (reserved).

Reset
REQ-029 rst_n=0 SHALL immediately force state RST, all controls 0, inst_q=0, operand=0, illegal=0, halted=0, including mid-wait or mid-instruction.
REQ-030 After rst_n rises, the first falling edge SHALL execute RST (pc_rst=1, mem_rst=1).

Verification
REQ-031 LDI: mem 0x02, 0xA5, ready=1 -> regs_wsel=0x04 one cycle with bus 0xA5, pc_inc twice, back in FETCH after 3 cycles.
REQ-032 MOV: 0x0D, 0x03 -> EXEC1 regs_rsel=0x08, regs_wsel=0x20 one cycle; 4 cycles total.
REQ-033 Wait: FETCH with mem_ready low 3 cycles -> state_o=1 held, inst_w/pc_inc gated; pc_inc and inst_w each pulse once on the ready cycle.
REQ-034 JMP 0x10, 0x40 -> EXEC0 pc_r=1, pc_w=1, pc_inc=0; next FETCH. HLT 0x18 -> halted=1, all controls 0 for 20 cycles.
REQ-035 Illegal 0x28 -> illegal=1, halted=1; rst_n pulse low mid-MOV EXEC1 -> outputs 0 immediately, illegal=0, RST then FETCH.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
// master = sequencer, slave = datapath and memory side.
interface cpu_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8
);
   logic [DATA_W-1:0] data_bus_in;
   logic              mem_ready;
   logic [NREGS-1:0]  regs_rsel;
   logic [NREGS-1:0]  regs_wsel;
   logic              mem_ce;
   logic              mem_oe;
   logic              mem_r;
   logic              mem_w;
   logic              mem_rst;
   logic              pc_r;
   logic              pc_w;
   logic              pc_inc;
   logic              pc_rst;
   logic              inst_w;
   logic [DATA_W-1:0] inst_q;
   logic [2:0]        state_o;
   logic              halted;
   logic              illegal;

   modport master (
      input  data_bus_in, mem_ready,
      output regs_rsel, regs_wsel,
      output mem_ce, mem_oe, mem_r, mem_w, mem_rst,
      output pc_r, pc_w, pc_inc, pc_rst, inst_w,
      output inst_q, state_o, halted, illegal
   );

   modport slave (
      output data_bus_in, mem_ready,
      input  regs_rsel, regs_wsel,
      input  mem_ce, mem_oe, mem_r, mem_w, mem_rst,
      input  pc_r, pc_w, pc_inc, pc_rst, inst_w,
      input  inst_q, state_o, halted, illegal
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FSM steps on falling clk,
// instruction/operand latches sample the bus on rising clk.
module cpu_sequencer #(
   parameter int DATA_W = 8,
   parameter int REG_W  = 3,
   parameter int NREGS  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   cpu_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC0  = 3'd3,
      S_EXEC1  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef struct packed {
      logic ce;
      logic oe;
      logic mr;
      logic mrst;
      logic pc_r;
      logic pc_w;
      logic pc_inc;
      logic pc_rst;
      logic inst_w;
      logic op_w;
   } ctl_t;

   localparam ctl_t C_NONE  = '0;
   localparam ctl_t C_RST   = '{mrst: 1'b1, pc_rst: 1'b1,
                                default: 1'b0};
   localparam ctl_t C_FETCH = '{ce: 1'b1, oe: 1'b1, mr: 1'b1,
                                pc_r: 1'b1, pc_inc: 1'b1,
                                inst_w: 1'b1, default: 1'b0};
   localparam ctl_t C_LDI   = '{ce: 1'b1, oe: 1'b1, mr: 1'b1,
                                pc_r: 1'b1, pc_inc: 1'b1,
                                default: 1'b0};
   localparam ctl_t C_MOV   = '{ce: 1'b1, oe: 1'b1, mr: 1'b1,
                                pc_r: 1'b1, pc_inc: 1'b1,
                                op_w: 1'b1, default: 1'b0};
   localparam ctl_t C_JMP   = '{ce: 1'b1, oe: 1'b1, mr: 1'b1,
                                pc_r: 1'b1, pc_w: 1'b1,
                                default: 1'b0};
   localparam logic [NREGS-1:0] ONE = NREGS'(1);

   state_t            r_state;
   ctl_t              r_ctl;
   logic [NREGS-1:0]  r_rsel;
   logic [NREGS-1:0]  r_wsel;
   logic [DATA_W-1:0] r_inst;
   logic [REG_W-1:0]  r_src;
   logic              r_halted;
   logic              r_illegal;

   logic              w_go;
   logic              w_stall;
   logic [4:0]        w_op;
   logic [REG_W-1:0]  w_rd;
   logic              w_rd_bad;
   logic              w_src_bad;

   // A memory step only completes when mem_ready is seen
   assign w_go      = ~r_ctl.mr | bus.mem_ready;
   assign w_stall   = ~w_go;
   assign w_op      = r_inst[REG_W+4:REG_W];
   assign w_rd      = r_inst[REG_W-1:0];
   assign w_rd_bad  = int'(w_rd) >= NREGS;
   assign w_src_bad = int'(r_src) >= NREGS;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RST;
         r_ctl     <= C_NONE;
         r_rsel    <= '0;
         r_wsel    <= '0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else if (!w_stall) begin
         r_ctl  <= C_NONE;
         r_rsel <= '0;
         r_wsel <= '0;
         case (r_state)
            S_RST: begin
               if (!r_ctl.pc_rst) begin
                  r_ctl <= C_RST;
               end else begin
                  r_state <= S_FETCH;
                  r_ctl   <= C_FETCH;
               end
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               r_state <= S_EXEC0;
               case (w_op)
                  5'd0: begin
                     if (w_rd_bad) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                     end else begin
                        r_ctl  <= C_LDI;
                        r_wsel <= ONE << w_rd;
                     end
                  end
                  5'd1: begin
                     if (w_rd_bad) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                     end else begin
                        r_ctl <= C_MOV;
                     end
                  end
                  5'd2: r_ctl <= C_JMP;
                  5'd3: begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end
                  5'd4: r_ctl <= C_NONE;
                  default: begin
                     r_state   <= S_HALT;
                     r_halted  <= 1'b1;
                     r_illegal <= 1'b1;
                  end
               endcase
            end
            S_EXEC0: begin
               if (w_op == 5'd1 && w_src_bad) begin
                  r_state   <= S_HALT;
                  r_halted  <= 1'b1;
                  r_illegal <= 1'b1;
               end else if (w_op == 5'd1) begin
                  r_state <= S_EXEC1;
                  r_rsel  <= ONE << r_src;
                  r_wsel  <= ONE << w_rd;
               end else begin
                  r_state <= S_FETCH;
                  r_ctl   <= C_FETCH;
               end
            end
            S_EXEC1: begin
               r_state <= S_FETCH;
               r_ctl   <= C_FETCH;
            end
            default: begin
               r_state  <= S_HALT;
               r_halted <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst <= '0;
         r_src  <= '0;
      end else begin
         if (r_ctl.inst_w && w_go)
            r_inst <= bus.data_bus_in;
         if (r_ctl.op_w && w_go)
            r_src <= bus.data_bus_in[REG_W-1:0];
      end
   end

   assign bus.mem_ce    = r_ctl.ce;
   assign bus.mem_oe    = r_ctl.oe;
   assign bus.mem_r     = r_ctl.mr;
   assign bus.mem_w     = 1'b0;
   assign bus.mem_rst   = r_ctl.mrst;
   assign bus.pc_r      = r_ctl.pc_r;
   assign bus.pc_rst    = r_ctl.pc_rst;
   assign bus.pc_w      = r_ctl.pc_w & w_go;
   assign bus.pc_inc    = r_ctl.pc_inc & w_go;
   assign bus.inst_w    = r_ctl.inst_w & w_go;
   assign bus.regs_rsel = r_rsel;
   assign bus.regs_wsel = r_wsel & {NREGS{w_go}};
   assign bus.inst_q    = r_inst;
   assign bus.state_o   = r_state;
   assign bus.halted    = r_halted;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: memory/PC/regfile datapath around the DUT
// plus an instruction-level reference interpreter.
module tb_cpu_sequencer;
   localparam int DW = 8;
   localparam int RW = 3;
   localparam int NR = 8;

   localparam logic [9:0] K_RST   = 10'b0000100010;
   localparam logic [9:0] K_FETCH = 10'b1110010101;
   localparam logic [9:0] K_WAIT  = 10'b1110010000;
   localparam logic [9:0] K_RD    = 10'b1110010100;
   localparam logic [9:0] K_JMP   = 10'b1110011000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cpu_sequencer_if #(.DATA_W(DW), .NREGS(NR)) ifc ();

   cpu_sequencer #(.DATA_W(DW), .REG_W(RW), .NREGS(NR)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   logic [7:0] mem [256];
   logic [7:0] rf  [NR];
   logic [7:0] mrf [NR];
   logic [7:0] pc;
   int n_fetch = 0;
   int chk = 0;
   int errs = 0;

   always_comb begin
      ifc.data_bus_in = '0;
      if (ifc.mem_ce && ifc.mem_oe)
         ifc.data_bus_in = mem[pc];
      else
         for (int i = 0; i < NR; i++)
            if (ifc.regs_rsel[i]) ifc.data_bus_in = rf[i];
   end

   always @(posedge clk) begin
      if (ifc.pc_rst) pc <= 8'd0;
      else if (ifc.pc_w) pc <= ifc.data_bus_in;
      else if (ifc.pc_inc) pc <= pc + 8'd1;
      for (int i = 0; i < NR; i++)
         if (ifc.regs_wsel[i]) rf[i] <= ifc.data_bus_in;
      if (ifc.inst_w) n_fetch <= n_fetch + 1;
   end

   function automatic logic [9:0] ctl();
      return {ifc.mem_ce, ifc.mem_oe, ifc.mem_r, ifc.mem_w,
              ifc.mem_rst, ifc.pc_r, ifc.pc_w, ifc.pc_inc,
              ifc.pc_rst, ifc.inst_w};
   endfunction

   task automatic step(input bit rdy);
      @(negedge clk);
      #1 ifc.mem_ready = rdy;
      #1;
   endtask

   task automatic load(input logic [7:0] p [$]);
      for (int a = 0; a < 256; a++) mem[a] = 8'h18;
      foreach (p[i]) mem[i] = p[i];
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifc.mem_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      load('{8'h20});
      rst_n = 1'b0;
      ifc.mem_ready = 1'b1;
      #12;
      chk++; if (ifc.state_o !== 3'd0) begin errs++;
         $display("FAIL rst_state got %0d want 0", ifc.state_o); end
      chk++; if (ctl() !== 10'd0) begin errs++;
         $display("FAIL rst_ctl got %b want 0", ctl()); end
      chk++; if ({ifc.inst_q, ifc.halted, ifc.illegal} !== 10'd0) begin
         errs++; $display("FAIL rst_regs got %h want 0",
                          {ifc.inst_q, ifc.halted, ifc.illegal}); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1);
      chk++; if ({ifc.state_o, ctl()} !== {3'd0, K_RST}) begin errs++;
         $display("FAIL rst_step got %0d/%b want 0/%b",
                  ifc.state_o, ctl(), K_RST); end
      step(1);
      chk++; if ({ifc.state_o, ctl()} !== {3'd1, K_FETCH}) begin errs++;
         $display("FAIL rst_fetch got %0d/%b want 1/%b",
                  ifc.state_o, ctl(), K_FETCH); end
   endtask

   task automatic test_ldi();
      load('{8'h02, 8'hA5, 8'h18});
      do_reset();
      step(1);
      step(1);
      chk++; if (ctl() !== K_FETCH) begin errs++;
         $display("FAIL ldi_fetch got %b want %b", ctl(), K_FETCH); end
      step(1);
      chk++; if ({ifc.state_o, ctl(), ifc.inst_q} !== {3'd2, 10'd0, 8'h02})
         begin errs++; $display("FAIL ldi_decode got %0d/%b/%h want 2/0/02",
                                ifc.state_o, ctl(), ifc.inst_q); end
      step(1);
      chk++; if ({ifc.state_o, ctl(), ifc.regs_wsel, ifc.data_bus_in} !==
                 {3'd3, K_RD, 8'h04, 8'hA5}) begin errs++;
         $display("FAIL ldi_exec got %0d/%b/%h/%h want 3/%b/04/a5",
                  ifc.state_o, ctl(), ifc.regs_wsel, ifc.data_bus_in, K_RD);
      end
      step(1);
      chk++; if ({ifc.state_o, rf[2], pc} !== {3'd1, 8'hA5, 8'd2}) begin
         errs++; $display("FAIL ldi_done got %0d/%h/%h want 1/a5/02",
                          ifc.state_o, rf[2], pc); end
   endtask

   task automatic test_mov();
      load('{8'h03, 8'h5A, 8'h0D, 8'h03, 8'h18});
      do_reset();
      repeat (4) step(1);
      repeat (2) step(1);
      step(1);
      chk++; if ({ifc.state_o, ctl(), ifc.regs_wsel} !==
                 {3'd3, K_RD, 8'h00}) begin errs++;
         $display("FAIL mov_exec0 got %0d/%b/%h want 3/%b/00",
                  ifc.state_o, ctl(), ifc.regs_wsel, K_RD); end
      step(1);
      chk++; if ({ifc.state_o, ctl(), ifc.regs_rsel, ifc.regs_wsel,
                  ifc.data_bus_in} !== {3'd4, 10'd0, 8'h08, 8'h20, 8'h5A})
      begin errs++;
         $display("FAIL mov_exec1 got %0d/%b/%h/%h/%h want 4/0/08/20/5a",
                  ifc.state_o, ctl(), ifc.regs_rsel, ifc.regs_wsel,
                  ifc.data_bus_in); end
      step(1);
      chk++; if ({ifc.state_o, rf[5], pc} !== {3'd1, 8'h5A, 8'd4}) begin
         errs++; $display("FAIL mov_done got %0d/%h/%h want 1/5a/04",
                          ifc.state_o, rf[5], pc); end
   endtask

   task automatic test_wait();
      int base;
      load('{8'h20, 8'h18});
      do_reset();
      step(1);
      base = n_fetch;
      for (int k = 0; k < 3; k++) begin
         step(0);
         chk++; if ({ifc.state_o, ctl(), pc} !== {3'd1, K_WAIT, 8'd0})
         begin errs++; $display("FAIL wait_hold%0d got %0d/%b/%h want 1/%b/00",
                                k, ifc.state_o, ctl(), pc, K_WAIT); end
      end
      step(1);
      chk++; if (ctl() !== K_FETCH) begin errs++;
         $display("FAIL wait_ready got %b want %b", ctl(), K_FETCH); end
      step(1);
      chk++; if ({ifc.state_o, pc, 8'(n_fetch - base)} !==
                 {3'd2, 8'd1, 8'd1}) begin errs++;
         $display("FAIL wait_once got %0d/%h/%0d want 2/01/1",
                  ifc.state_o, pc, n_fetch - base); end
   endtask

   task automatic test_jmp_hlt();
      logic [26:0] obs;
      load('{8'h10, 8'h40});
      mem[8'h40] = 8'h18;
      do_reset();
      repeat (3) step(1);
      step(1);
      chk++; if ({ifc.state_o, ctl()} !== {3'd3, K_JMP}) begin errs++;
         $display("FAIL jmp_exec got %0d/%b want 3/%b",
                  ifc.state_o, ctl(), K_JMP); end
      step(1);
      chk++; if ({ifc.state_o, pc} !== {3'd1, 8'h40}) begin errs++;
         $display("FAIL jmp_target got %0d/%h want 1/40", ifc.state_o, pc);
      end
      repeat (2) step(1);
      chk++; if ({ifc.state_o, ifc.halted, ifc.illegal} !== {3'd5, 2'b10})
      begin errs++; $display("FAIL hlt_enter got %0d/%b%b want 5/10",
                             ifc.state_o, ifc.halted, ifc.illegal); end
      for (int k = 0; k < 20; k++) begin
         step(1'($urandom));
         obs = {ctl(), ifc.regs_rsel, ifc.regs_wsel, ifc.halted};
         chk++; if (obs !== 27'd1) begin errs++;
            $display("FAIL hlt_quiet%0d got %h want 0000001", k, obs); end
      end
   endtask

   task automatic test_illegal();
      load('{8'h28});
      do_reset();
      repeat (4) step(1);
      chk++; if ({ifc.state_o, ifc.illegal, ifc.halted, ctl()} !==
                 {3'd5, 2'b11, 10'd0}) begin errs++;
         $display("FAIL illegal got %0d/%b%b/%b want 5/11/0",
                  ifc.state_o, ifc.illegal, ifc.halted, ctl()); end
   endtask

   task automatic test_reset_mid();
      load('{8'h03, 8'h5A, 8'h0D, 8'h03, 8'h18});
      rst_n = 1'b0;
      #1;
      chk++; if ({ifc.illegal, ifc.halted} !== 2'b00) begin errs++;
         $display("FAIL midrst_sticky got %b want 00",
                  {ifc.illegal, ifc.halted}); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) step(1);
      chk++; if (ifc.state_o !== 3'd4) begin errs++;
         $display("FAIL midrst_pre got %0d want 4", ifc.state_o); end
      #1 rst_n = 1'b0;
      #1;
      chk++; if ({ifc.state_o, ctl(), ifc.regs_rsel, ifc.regs_wsel,
                  ifc.inst_q} !== 37'd0) begin errs++;
         $display("FAIL midrst_now got %0d/%b/%h/%h/%h want all 0",
                  ifc.state_o, ctl(), ifc.regs_rsel, ifc.regs_wsel,
                  ifc.inst_q); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1);
      chk++; if ({ifc.state_o, ctl()} !== {3'd0, K_RST}) begin errs++;
         $display("FAIL midrst_rst got %0d/%b want 0/%b",
                  ifc.state_o, ctl(), K_RST); end
      step(1);
      chk++; if (ifc.state_o !== 3'd1) begin errs++;
         $display("FAIL midrst_fetch got %0d want 1", ifc.state_o); end
   endtask

   task automatic test_random();
      int pos, tgt, cyc, base, mcyc, minst;
      logic [7:0] ins, opd, mpc;
      bit zw, done;
      for (int it = 0; it < 12; it++) begin
         zw = (it % 2) == 0;
         for (int a = 0; a < 256; a++) mem[a] = 8'h18;
         pos = 0;
         repeat ($urandom_range(4, 16)) begin
            case ($urandom_range(0, 3))
               0: begin
                  mem[pos] = {5'd0, 3'($urandom)};
                  mem[pos+1] = 8'($urandom);
                  pos += 2;
               end
               1: begin
                  mem[pos] = {5'd1, 3'($urandom)};
                  mem[pos+1] = 8'($urandom);
                  pos += 2;
               end
               2: begin
                  tgt = pos + 2 + int'($urandom_range(0, 3));
                  mem[pos] = {5'd2, 3'($urandom)};
                  mem[pos+1] = 8'(tgt);
                  for (int a = pos + 2; a < tgt; a++) mem[a] = 8'($urandom);
                  pos = tgt;
               end
               default: begin
                  mem[pos] = {5'd4, 3'($urandom)};
                  pos += 1;
               end
            endcase
         end
         do_reset();
         mrf = rf;
         mpc = 8'd0; mcyc = 0; minst = 0; done = 1'b0;
         for (int k = 0; k < 500 && !done; k++) begin
            ins = mem[mpc]; mpc++; minst++; mcyc += 2;
            case (ins[7:3])
               5'd0: begin mrf[ins[2:0]] = mem[mpc]; mpc++; mcyc += 1; end
               5'd1: begin
                  opd = mem[mpc]; mpc++;
                  mrf[ins[2:0]] = mrf[opd[2:0]]; mcyc += 2;
               end
               5'd2: begin mpc = mem[mpc]; mcyc += 1; end
               5'd4: mcyc += 1;
               default: done = 1'b1;
            endcase
         end
         step(1);
         base = n_fetch;
         cyc = 0;
         for (int c = 0; c < 4000 && ifc.halted !== 1'b1; c++) begin
            step(zw ? 1'b1 : ($urandom_range(0, 3) != 0));
            if (ifc.state_o inside {[3'd1 : 3'd4]}) cyc++;
         end
         chk++; if ({ifc.halted, ifc.illegal} !== 2'b10) begin errs++;
            $display("FAIL rnd%0d_halt got %b%b want 10",
                     it, ifc.halted, ifc.illegal); end
         chk++; if (pc !== mpc) begin errs++;
            $display("FAIL rnd%0d_pc got %h want %h", it, pc, mpc); end
         chk++; if (n_fetch - base !== minst) begin errs++;
            $display("FAIL rnd%0d_insts got %0d want %0d",
                     it, n_fetch - base, minst); end
         for (int r = 0; r < NR; r++) begin
            chk++; if (rf[r] !== mrf[r]) begin errs++;
               $display("FAIL rnd%0d_r%0d got %h want %h",
                        it, r, rf[r], mrf[r]); end
         end
         if (zw) begin
            chk++; if (cyc !== mcyc) begin errs++;
               $display("FAIL rnd%0d_cycles got %0d want %0d",
                        it, cyc, mcyc); end
         end
      end
   endtask

   initial begin
      ifc.mem_ready = 1'b1;
      test_reset();
      test_ldi();
      test_mov();
      test_wait();
      test_jmp_hlt();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, errs);
      $finish;
   end
endmodule
